// File: rtl/cont2_pkg.sv
// Shared types and helpers for the up/down counter sequence checker.
// Holds the FSM encoding, default width and index-to-value mapping.
package cont2_pkg;

  localparam int CONT2_WIDTH = 4;
  localparam int CONT2_CNT_W = 8;
  localparam logic [CONT2_CNT_W-1:0] CONT2_CNT_MAX = '1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } cont2_state_t;

  // Upper half of the index runs the count back down: value = ~index.
  function automatic logic [15:0] cont2_value(
    input logic [15:0] idx,
    input int          w
  );
    logic [15:0] mask;
    mask = (16'd1 << w) - 16'd1;
    if (idx[w]) begin
      return ~idx & mask;
    end
    return idx & mask;
  endfunction

endpackage

// File: rtl/cont2_seq_predictor.sv
// Combinational map from sequence index to the reference count value.
// Index is WIDTH+1 bits; values rise 0..MAX then fall MAX..0.
module cont2_seq_predictor
  import cont2_pkg::*;
#(
  parameter int WIDTH = CONT2_WIDTH
) (
  input  logic [WIDTH:0]   idx,
  output logic [WIDTH-1:0] val
);

  logic [15:0] wide;

  assign wide = cont2_value(16'(idx), WIDTH);
  assign val  = WIDTH'(wide);

endmodule

// File: rtl/cont2_checker.sv
// Lock-and-track checker for a 0..MAX..0 up/down counter stream.
// Define CONT2_CHK_ERRCNT_EN to build the saturating ErrCount register.
module cont2_checker
  import cont2_pkg::*;
#(
  parameter int WIDTH = CONT2_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In,
  input  logic             In_Valid,
  output logic             Locked,
  output logic             Error,
  output logic [WIDTH-1:0] Expected,
  output logic [7:0]       ErrCount
);

  localparam logic [WIDTH-1:0] MAXV = '1;

  cont2_state_t     state_q;
  cont2_state_t     state_d;
  logic [WIDTH:0]   idx_q;
  logic [WIDTH:0]   idx_d;
  logic [WIDTH:0]   idx_nx;
  logic [WIDTH-1:0] first_q;
  logic [WIDTH-1:0] first_d;
  logic             err_q;
  logic             err_d;
  logic [WIDTH-1:0] pred;
  logic [WIDTH:0]   in_w;
  logic [WIDTH:0]   first_w;
  logic             up;
  logic             dn;
  logic             top;
  logic             bot;

  assign idx_nx = idx_q + 1'b1;

  cont2_seq_predictor #(
    .WIDTH (WIDTH)
  ) u_pred (
    .idx (idx_nx),
    .val (pred)
  );

  // Widen before comparing so MAX->0 and 0->MAX never look adjacent.
  assign in_w    = {1'b0, In};
  assign first_w = {1'b0, first_q};
  assign up      = (in_w == first_w + 1'b1);
  assign dn      = (first_w == in_w + 1'b1);
  assign top     = (In == first_q) && (In == MAXV);
  assign bot     = (In == first_q) && (In == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    first_d = first_q;
    err_d   = 1'b0;
    if (In_Valid) begin
      unique case (state_q)
        HUNT: begin
          first_d = In;
          state_d = SYNC;
        end
        SYNC: begin
          unique case (1'b1)
            up: begin
              idx_d   = in_w;
              state_d = LOCKED;
            end
            dn: begin
              idx_d   = ~in_w;
              state_d = LOCKED;
            end
            top: begin
              idx_d   = {1'b1, {WIDTH{1'b0}}};
              state_d = LOCKED;
            end
            bot: begin
              idx_d   = '0;
              state_d = LOCKED;
            end
            default: begin
              first_d = In;
            end
          endcase
        end
        LOCKED: begin
          if (In == pred) begin
            idx_d = idx_nx;
          end else begin
            err_d   = 1'b1;
            first_d = In;
            state_d = SYNC;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= HUNT;
      idx_q   <= '0;
      first_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

`ifdef CONT2_CHK_ERRCNT_EN
  logic [CONT2_CNT_W-1:0] cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (err_d && (cnt_q != CONT2_CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ErrCount = cnt_q;
`else
  assign ErrCount = 8'd0;
`endif

  assign Locked   = (state_q == LOCKED);
  assign Error    = err_q;
  assign Expected = Locked ? pred : '0;

endmodule

// File: tb/tb_cont2_checker.sv
// Directed self-checking bench for cont2_checker (WIDTH=4).
module tb_cont2_checker;

  logic       Clock;
  logic       Reset;
  logic [3:0] In;
  logic       In_Valid;
  logic       Locked;
  logic       Error;
  logic [3:0] Expected;
  logic [7:0] ErrCount;

  int checks;
  int errors;

`ifdef CONT2_CHK_ERRCNT_EN
  localparam int ONE_ERR = 1;
  localparam int SAT_ERR = 255;
`else
  localparam int ONE_ERR = 0;
  localparam int SAT_ERR = 0;
`endif

  cont2_checker #(.WIDTH(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .In       (In),
    .In_Valid (In_Valid),
    .Locked   (Locked),
    .Error    (Error),
    .Expected (Expected),
    .ErrCount (ErrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int refv(input int i);
    int k;
    k = i % 32;
    return (k <= 15) ? k : 31 - k;
  endfunction

  task automatic step(input logic v, input int d);
    In_Valid = v;
    In       = 4'(d);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset    = 1'b1;
    In_Valid = 1'b1;
    In       = 4'd5;
    @(posedge Clock);
    #1;
    Reset    = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (Locked !== 1'b0 || Error !== 1'b0 ||
        Expected !== 4'd0 || ErrCount !== 8'd0) begin
      errors++;
      $display("FAIL reset: L=%b E=%b X=%0d C=%0d want 0 0 0 0",
               Locked, Error, Expected, ErrCount);
    end
  endtask

  task automatic test_full_seq();
    int n;
    do_reset();
    for (int p = 0; p < 34; p++) begin
      step(1'b1, refv(p));
      checks++;
      if (p == 0) begin
        if (Locked !== 1'b0) begin
          errors++;
          $display("FAIL seq_first: Locked=%b want 0", Locked);
        end
      end else begin
        n = refv(p + 1);
        if (Locked !== 1'b1 || Error !== 1'b0 ||
            Expected !== 4'(n)) begin
          errors++;
          $display("FAIL seq p=%0d: L=%b E=%b X=%0d want 1 0 %0d",
                   p, Locked, Error, Expected, n);
        end
      end
    end
    checks++;
    if (ErrCount !== 8'd0) begin
      errors++;
      $display("FAIL seq_cnt: ErrCount=%0d want 0", ErrCount);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    for (int v = 0; v <= 5; v++) step(1'b1, v);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd6) begin
      errors++;
      $display("FAIL mis_pre: L=%b X=%0d want 1 6", Locked, Expected);
    end
    step(1'b1, 7);
    checks++;
    if (Error !== 1'b1 || Locked !== 1'b0 || Expected !== 4'd0 ||
        ErrCount !== 8'(ONE_ERR)) begin
      errors++;
      $display("FAIL mis_hit: E=%b L=%b X=%0d C=%0d want 1 0 0 %0d",
               Error, Locked, Expected, ErrCount, ONE_ERR);
    end
    step(1'b1, 8);
    checks++;
    if (Error !== 1'b0 || Locked !== 1'b1 || Expected !== 4'd9) begin
      errors++;
      $display("FAIL mis_relock: E=%b L=%b X=%0d want 0 1 9",
               Error, Locked, Expected);
    end
    step(1'b1, 9);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd10 ||
        ErrCount !== 8'(ONE_ERR)) begin
      errors++;
      $display("FAIL mis_track: L=%b X=%0d C=%0d want 1 10 %0d",
               Locked, Expected, ErrCount, ONE_ERR);
    end
  endtask

  task automatic test_downcount();
    do_reset();
    step(1'b1, 9);
    step(1'b1, 8);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd7) begin
      errors++;
      $display("FAIL down: L=%b X=%0d want 1 7", Locked, Expected);
    end
    step(1'b1, 7);
    checks++;
    if (Error !== 1'b0 || Expected !== 4'd6) begin
      errors++;
      $display("FAIL down_next: E=%b X=%0d want 0 6", Error, Expected);
    end
  endtask

  task automatic test_dwell();
    do_reset();
    step(1'b1, 15);
    step(1'b1, 15);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd14) begin
      errors++;
      $display("FAIL top_dwell: L=%b X=%0d want 1 14", Locked, Expected);
    end
    do_reset();
    step(1'b1, 0);
    step(1'b1, 0);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd1) begin
      errors++;
      $display("FAIL bot_dwell: L=%b X=%0d want 1 1", Locked, Expected);
    end
    do_reset();
    step(1'b1, 3);
    step(1'b1, 3);
    checks++;
    if (Locked !== 1'b0 || Error !== 1'b0) begin
      errors++;
      $display("FAIL no_lock: L=%b E=%b want 0 0", Locked, Error);
    end
    do_reset();
    step(1'b1, 14);
    step(1'b1, 15);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd15) begin
      errors++;
      $display("FAIL top_exp: L=%b X=%0d want 1 15", Locked, Expected);
    end
    step(1'b1, 14);
    checks++;
    if (Error !== 1'b1 || Locked !== 1'b0) begin
      errors++;
      $display("FAIL top_miss: E=%b L=%b want 1 0", Error, Locked);
    end
    step(1'b1, 1);
    step(1'b1, 15);
    checks++;
    if (Locked !== 1'b0) begin
      errors++;
      $display("FAIL no_wrap_pair: Locked=%b want 0", Locked);
    end
  endtask

  task automatic test_gap();
    do_reset();
    for (int v = 0; v <= 4; v++) step(1'b1, v);
    for (int g = 0; g < 5; g++) begin
      step(1'b0, 11);
      checks++;
      if (Locked !== 1'b1 || Error !== 1'b0 || Expected !== 4'd5) begin
        errors++;
        $display("FAIL gap g=%0d: L=%b E=%b X=%0d want 1 0 5",
                 g, Locked, Error, Expected);
      end
    end
    step(1'b1, 5);
    checks++;
    if (Error !== 1'b0 || Expected !== 4'd6) begin
      errors++;
      $display("FAIL gap_end: E=%b X=%0d want 0 6", Error, Expected);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int v = 3; v <= 6; v++) step(1'b1, v);
    do_reset();
    checks++;
    if (Locked !== 1'b0 || Expected !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid: L=%b X=%0d want 0 0", Locked, Expected);
    end
    step(1'b1, 7);
    checks++;
    if (Locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_one: Locked=%b want 0", Locked);
    end
    step(1'b1, 8);
    checks++;
    if (Locked !== 1'b1 || Expected !== 4'd9) begin
      errors++;
      $display("FAIL rst_relock: L=%b X=%0d want 1 9", Locked, Expected);
    end
  endtask

  task automatic test_errcnt();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      step(1'b1, 3);
      step(1'b1, 4);
      step(1'b1, 10);
    end
    checks++;
    if (ErrCount !== 8'(SAT_ERR)) begin
      errors++;
      $display("FAIL errcnt_sat: ErrCount=%0d want %0d",
               ErrCount, SAT_ERR);
    end
    do_reset();
    checks++;
    if (ErrCount !== 8'd0 || Locked !== 1'b0) begin
      errors++;
      $display("FAIL errcnt_rst: C=%0d L=%b want 0 0", ErrCount, Locked);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    Reset    = 1'b0;
    In       = 4'd0;
    In_Valid = 1'b0;
    @(negedge Clock);
    test_reset();
    test_full_seq();
    test_mismatch();
    test_downcount();
    test_dwell();
    test_gap();
    test_reset_mid();
    test_errcnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
